ex_mdu: RTL
===========

Name: ex_mdu

Overview:
- Multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the operand values and the decoded multiply/divide op that the ID/EX register holds.
- Owns the architectural HI/LO registers and models multi-cycle latency with a busy counter.
- Exports start/busy to the hazard unit, which stalls the front end and bubbles ID/EX while a result is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- md_op  in  4  op from the ID/EX register: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 are treated as NONE.
- op_valid  in  1  EX holds a real instruction; 0 means bubble (all-zero ID/EX contents).
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / MTHI-MTLO source).
- rt_val  in  32  forwarded rt operand (divisor / multiplier).
- start  out  1  combinational: op_valid & md_op in {1..4} & ~busy.
- busy  out  1  registered: multi-cycle operation in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- rd_data  out  32  combinational: hi when md_op=MFHI, lo when md_op=MFLO, else 0.

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, cnt=0, pend_hi=0, pend_lo=0, pend_commit=0, busy=0.
- Internal state:
  - cnt: 4-bit down-counter, sized to hold max(MULT_CYCLES, DIV_CYCLES).
  - pend_hi/pend_lo: 32-bit result holding registers.
  - pend_commit: 1 bit.
- busy = (cnt != 0).
- Issue (start=1 at edge T):
  - Result is computed combinationally from rs_val/rt_val and latched into pend_hi/pend_lo.
  - cnt <= MULT_CYCLES or DIV_CYCLES; pend_commit <= 1, except divide-by-zero, which sets pend_commit <= 0.
- Countdown:
  - Each edge with cnt != 0: cnt <= cnt-1.
  - On the edge where cnt==1, if pend_commit: hi <= pend_hi, lo <= pend_lo.
  - busy is therefore high for exactly N cycles after the issue edge. New HI/LO is visible in the first cycle busy=0.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {hi,lo} = product.
  - MULTU: same, unsigned.
  - DIV: signed, lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
  - DIV/DIVU by zero: HI/LO unchanged; the busy period still runs its full length.
- MTHI/MTLO:
  - When op_valid & ~busy, hi (or lo) <= rs_val at the next edge; 1-cycle effect, no busy.
  - When busy: ignored.
- MFHI/MFLO: rd_data reflects current hi/lo combinationally. While busy it returns pre-operation values; the hazard unit must stall any MF* while start|busy.
- Mul/div op arriving while busy: ignored, no restart, no state change. The hazard unit guarantees this does not occur; verification flags it as an assertion.
- op_valid=0: no state change regardless of md_op; rd_data still decodes md_op.
- Reset asserted mid-operation: everything clears immediately. The pending result is discarded and hi/lo return to 0.
- Commit and MTHI/MTLO on the same edge cannot happen (MT* requires ~busy), so no arbitration is needed.

Decomposition:
- Package mdu_pkg:
  - md_op encodings (MD_NONE..MD_MTLO) as localparams/typedef enum, shared with the controller decode and the ID/EX op field.
  - Default latency constants.
- One sub-module: mdu_arith.
  - Combinational; md_op, rs_val, rt_val -> res_hi, res_lo, div_zero.
  - Isolates the multiply/divide datapath and its special cases from the sequencing logic.

Test Plan:
- Reset then MULT rs=0xFFFFFFFE (-2), rt=3:
  - start=1 for one cycle, busy high 5 cycles.
  - After busy falls: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo stay 0 while busy.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after exactly 10 busy cycles. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then MFLO: hi=0x12345678 next cycle. Then DIVU 5/0 -> busy 10 cycles, hi still 0x12345678, lo unchanged.
- Mid-DIV checks:
  - MTLO 0xAAAA during busy is ignored.
  - A second MULT during busy is ignored: no restart, busy still falls on the original cycle.
  - MFHI during busy returns the old hi.
- Assert reset=0 at busy cycle 3 of a DIV: busy, hi, lo drop to 0 asynchronously (before the next edge). After release, no late commit occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// md_op encodings carried in the ID/EX op field and default latencies.
package mdu_pkg;

    typedef logic [3:0] md_op_t;

    localparam md_op_t MD_NONE  = 4'd0;
    localparam md_op_t MD_MULT  = 4'd1;
    localparam md_op_t MD_MULTU = 4'd2;
    localparam md_op_t MD_DIV   = 4'd3;
    localparam md_op_t MD_DIVU  = 4'd4;
    localparam md_op_t MD_MFHI  = 4'd5;
    localparam md_op_t MD_MFLO  = 4'd6;
    localparam md_op_t MD_MTHI  = 4'd7;
    localparam md_op_t MD_MTLO  = 4'd8;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    function automatic logic is_muldiv(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
// Ports: i_md_op, i_rs_val, i_rt_val -> o_res_hi, o_res_lo, o_div_zero.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  i_md_op,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_div_zero
);

    logic signed [63:0] w_smul;
    logic        [63:0] w_umul;
    logic               w_sdiv;
    logic        [31:0] w_a;
    logic        [31:0] w_b;
    logic        [31:0] w_b_safe;
    logic        [31:0] w_q;
    logic        [31:0] w_r;
    logic               w_qneg;
    logic               w_rneg;
    logic               w_is_div;

    assign w_smul = $signed({{32{i_rs_val[31]}}, i_rs_val}) *
                    $signed({{32{i_rt_val[31]}}, i_rt_val});
    assign w_umul = {32'b0, i_rs_val} * {32'b0, i_rt_val};

    // Signed divide runs on magnitudes; signs are restored afterwards.
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign w_sdiv   = (i_md_op == MD_DIV);
    assign w_is_div = (i_md_op == MD_DIV) || (i_md_op == MD_DIVU);
    assign w_a      = (w_sdiv && i_rs_val[31]) ? -i_rs_val : i_rs_val;
    assign w_b      = (w_sdiv && i_rt_val[31]) ? -i_rt_val : i_rt_val;
    // Keep the divider free of X when the divisor is zero.
    assign w_b_safe = (w_b == 32'd0) ? 32'd1 : w_b;
    assign w_q      = w_a / w_b_safe;
    assign w_r      = w_a % w_b_safe;
    assign w_qneg   = w_sdiv && (i_rs_val[31] ^ i_rt_val[31]);
    assign w_rneg   = w_sdiv && i_rs_val[31];

    assign o_div_zero = w_is_div && (i_rt_val == 32'd0);

    always_comb begin
        o_res_hi = 32'd0;
        o_res_lo = 32'd0;
        case (i_md_op)
            MD_MULT: begin
                o_res_hi = w_smul[63:32];
                o_res_lo = w_smul[31:0];
            end
            MD_MULTU: begin
                o_res_hi = w_umul[63:32];
                o_res_lo = w_umul[31:0];
            end
            MD_DIV, MD_DIVU: begin
                o_res_hi = w_rneg ? -w_r : w_r;
                o_res_lo = w_qneg ? -w_q : w_q;
            end
            default: begin
                o_res_hi = 32'd0;
                o_res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit owning HI/LO with modelled latency.
// Ports: clk, reset (async, active-low), md_op, op_valid, rs_val,
// rt_val -> start, busy, hi, lo, rd_data.
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        op_valid,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int unsigned MAX_CYC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_commit;

    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;
    logic             w_is_mul;
    logic             w_mthi;
    logic             w_mtlo;

    mdu_arith u_arith (
        .i_md_op    (md_op),
        .i_rs_val   (rs_val),
        .i_rt_val   (rt_val),
        .o_res_hi   (w_res_hi),
        .o_res_lo   (w_res_lo),
        .o_div_zero (w_div_zero)
    );

    assign busy     = (r_cnt != '0);
    assign start    = op_valid && is_muldiv(md_op) && !busy;
    assign w_is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign w_mthi   = op_valid && !busy && (md_op == MD_MTHI);
    assign w_mtlo   = op_valid && !busy && (md_op == MD_MTLO);
    assign hi       = r_hi;
    assign lo       = r_lo;

    always_comb begin
        rd_data = 32'd0;
        case (md_op)
            MD_MFHI: rd_data = r_hi;
            MD_MFLO: rd_data = r_lo;
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_hi          <= 32'd0;
            r_lo          <= 32'd0;
            r_pend_hi     <= 32'd0;
            r_pend_lo     <= 32'd0;
            r_pend_commit <= 1'b0;
        end else begin
            if (start) begin
                r_pend_hi     <= w_res_hi;
                r_pend_lo     <= w_res_lo;
                r_cnt         <= w_is_mul ? CNT_W'(MULT_CYCLES)
                                          : CNT_W'(DIV_CYCLES);
                // Divide-by-zero still occupies the unit but leaves HI/LO.
                r_pend_commit <= !w_div_zero;
            end else if (busy) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1) && r_pend_commit) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end
            // MT* only fires when idle, so it never meets a commit.
            if (w_mthi) begin
                r_hi <= rs_val;
            end
            if (w_mtlo) begin
                r_lo <= rs_val;
            end
        end
    end

endmodule
